// File: rtl/adxl345_pkg.sv
// Shared definitions for the ADXL345 SPI responder: register addresses,
// reset values, address classification helpers and the frame state enum.
package adxl345_pkg;

  localparam logic [5:0] DEVID_A       = 6'h00;
  localparam logic [5:0] BW_RATE_A     = 6'h2C;
  localparam logic [5:0] POWER_CTL_A   = 6'h2D;
  localparam logic [5:0] INT_SOURCE_A  = 6'h30;
  localparam logic [5:0] DATA_FORMAT_A = 6'h31;
  localparam logic [5:0] DATAX0_A      = 6'h32;
  localparam logic [5:0] DATAX1_A      = 6'h33;
  localparam logic [5:0] DATAY0_A      = 6'h34;
  localparam logic [5:0] DATAY1_A      = 6'h35;
  localparam logic [5:0] DATAZ0_A      = 6'h36;
  localparam logic [5:0] DATAZ1_A      = 6'h37;
  localparam logic [5:0] FIFO_STATUS_A = 6'h39;

  localparam logic [7:0] BW_RATE_RST    = 8'h0A;
  localparam logic [7:0] INT_SOURCE_RST = 8'h02;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  // Addresses the SPI master may modify; everything else drops writes.
  function automatic logic is_writable(input logic [5:0] a);
    return ((a >= 6'h1D) && (a <= 6'h2A)) ||
           ((a >= 6'h2C) && (a <= 6'h2F)) ||
           (a == 6'h31) || (a == 6'h38);
  endfunction

  // Axis sample registers; reading any of them consumes DATA_READY.
  function automatic logic is_data_reg(input logic [5:0] a);
    return (a >= DATAX0_A) && (a <= DATAZ1_A);
  endfunction

endpackage

// File: rtl/adxl345_spi_responder_spi_edge_sync.sv
// Synchronizes the SPI pins into the clk domain and derives one-cycle
// edge pulses for chip select and the SPI clock.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic spi_clk,
  input  logic mosi,
  output logic cs_rise,
  output logic cs_fall,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_s
);

  logic [STAGES-1:0] cs_pipe_r;
  logic [STAGES-1:0] sclk_pipe_r;
  logic [STAGES-1:0] mosi_pipe_r;
  logic              cs_prev_r;
  logic              sclk_prev_r;
  logic              cs_s;
  logic              sclk_s;

  // Synchronizer chains plus one history stage for edge detection; idle bus levels on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_pipe_r   <= {STAGES{1'b1}};
      sclk_pipe_r <= {STAGES{1'b1}};
      mosi_pipe_r <= {STAGES{1'b0}};
      cs_prev_r   <= 1'b1;
      sclk_prev_r <= 1'b1;
    end else begin
      cs_pipe_r   <= {cs_pipe_r[STAGES-2:0], cs};
      sclk_pipe_r <= {sclk_pipe_r[STAGES-2:0], spi_clk};
      mosi_pipe_r <= {mosi_pipe_r[STAGES-2:0], mosi};
      cs_prev_r   <= cs_s;
      sclk_prev_r <= sclk_s;
    end
  end

  assign cs_s   = cs_pipe_r[STAGES-1];
  assign sclk_s = sclk_pipe_r[STAGES-1];
  assign mosi_s = mosi_pipe_r[STAGES-1];

  assign cs_rise = cs_s & ~cs_prev_r;
  assign cs_fall = ~cs_s & cs_prev_r;

  // Gating on the previous CS level lets an SPI edge that coincides with
  // CS rising still complete its byte, while edges during idle are ignored.
  assign sclk_rise = sclk_s & ~sclk_prev_r & ~cs_prev_r;
  assign sclk_fall = ~sclk_s & sclk_prev_r & ~cs_prev_r;

endmodule

// File: rtl/adxl345_spi_responder.sv
// SPI mode-3 slave emulating the ADXL345 register interface: 64-entry
// register map, coherent X/Y/Z snapshot and configuration exports.
module adxl345_spi_responder
  import adxl345_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CS,
  input  logic        spi_clk,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] x_data,
  input  logic [15:0] y_data,
  input  logic [15:0] z_data,
  input  logic        sample_valid,
  output logic [7:0]  data_format,
  output logic [7:0]  power_ctl,
  output logic        measure,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data
);

  logic        cs_rise_s;
  logic        cs_fall_s;
  logic        sclk_rise_s;
  logic        sclk_fall_s;
  logic        mosi_s;

  state_t      state_r;
  logic [2:0]  bit_cnt_r;
  logic [6:0]  rx_shift_r;
  logic [7:0]  tx_shift_r;
  logic        rw_r;
  logic        mb_r;
  logic [5:0]  addr_r;
  logic        miso_r;
  logic [7:0]  regs_r [64];
  logic        wr_strobe_r;
  logic [5:0]  wr_addr_r;
  logic [7:0]  wr_data_r;
  logic        data_rd_seen_r;

  logic [15:0] x_snap_r, y_snap_r, z_snap_r;
  logic [15:0] x_pend_r, y_pend_r, z_pend_r;
  logic        pend_valid_r;
  logic        data_ready_r;

  logic [7:0]  rx_byte_s;
  logic [5:0]  next_addr_s;
  logic [5:0]  rd_addr_s;
  logic [7:0]  rd_data_s;
  logic        byte_end_s;
  logic        data_hit_s;
  logic        frame_active_s;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .cs        (CS),
    .spi_clk   (spi_clk),
    .mosi      (MOSI),
    .cs_rise   (cs_rise_s),
    .cs_fall   (cs_fall_s),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s),
    .mosi_s    (mosi_s)
  );

  assign rx_byte_s      = {rx_shift_r, mosi_s};
  assign next_addr_s    = mb_r ? (addr_r + 6'd1) : addr_r;
  assign byte_end_s     = sclk_rise_s && (bit_cnt_r == 3'd7);
  assign data_hit_s     = byte_end_s && (state_r == DATA) && rw_r && is_data_reg(addr_r);
  assign frame_active_s = (state_r != IDLE);
  // The command byte addresses the first read; later bytes use the advanced address.
  assign rd_addr_s      = (state_r == CMD) ? rx_byte_s[5:0] : next_addr_s;

  // Read mux: stored registers, identity, status and the frozen axis snapshot.
  always_comb begin
    rd_data_s = 8'h00;
    if (is_writable(rd_addr_s)) begin
      rd_data_s = regs_r[rd_addr_s];
    end else begin
      case (rd_addr_s)
        DEVID_A:      rd_data_s = DEVID;
        INT_SOURCE_A: rd_data_s = {data_ready_r, INT_SOURCE_RST[6:0]};
        DATAX0_A:     rd_data_s = x_snap_r[7:0];
        DATAX1_A:     rd_data_s = x_snap_r[15:8];
        DATAY0_A:     rd_data_s = y_snap_r[7:0];
        DATAY1_A:     rd_data_s = y_snap_r[15:8];
        DATAZ0_A:     rd_data_s = z_snap_r[7:0];
        DATAZ1_A:     rd_data_s = z_snap_r[15:8];
        FIFO_STATUS_A: rd_data_s = 8'h00;
        default:      rd_data_s = 8'h00;
      endcase
    end
  end

  // Frame FSM: command decode, byte shifting, register writes and write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      bit_cnt_r      <= 3'd0;
      rx_shift_r     <= 7'd0;
      tx_shift_r     <= 8'h00;
      rw_r           <= 1'b0;
      mb_r           <= 1'b0;
      addr_r         <= 6'd0;
      miso_r         <= 1'b0;
      wr_strobe_r    <= 1'b0;
      wr_addr_r      <= 6'd0;
      wr_data_r      <= 8'h00;
      data_rd_seen_r <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        regs_r[i[5:0]] <= 8'h00;
      end
      regs_r[BW_RATE_A] <= BW_RATE_RST;
    end else begin
      wr_strobe_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            state_r        <= CMD;
            bit_cnt_r      <= 3'd0;
            miso_r         <= 1'b0;
            data_rd_seen_r <= 1'b0;
          end
        end
        CMD: begin
          if (sclk_rise_s) begin
            rx_shift_r <= rx_byte_s[6:0];
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              rw_r       <= rx_byte_s[7];
              mb_r       <= rx_byte_s[6];
              addr_r     <= rx_byte_s[5:0];
              tx_shift_r <= rx_byte_s[7] ? rd_data_s : 8'h00;
              state_r    <= DATA;
            end
          end
          if (cs_rise_s) begin
            state_r <= IDLE;
            miso_r  <= 1'b0;
          end
        end
        DATA: begin
          if (sclk_fall_s) begin
            if (rw_r) begin
              miso_r     <= tx_shift_r[7];
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end else begin
              miso_r <= 1'b0;
            end
          end
          if (sclk_rise_s) begin
            rx_shift_r <= rx_byte_s[6:0];
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              if (!rw_r && is_writable(addr_r)) begin
                regs_r[addr_r] <= rx_byte_s;
                wr_strobe_r    <= 1'b1;
                wr_addr_r      <= addr_r;
                wr_data_r      <= rx_byte_s;
              end
              if (data_hit_s) begin
                data_rd_seen_r <= 1'b1;
              end
              addr_r <= next_addr_s;
              if (rw_r) begin
                tx_shift_r <= rd_data_s;
              end
            end
          end
          if (cs_rise_s) begin
            state_r <= IDLE;
            miso_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          miso_r  <= 1'b0;
        end
      endcase
    end
  end

  // Axis snapshot: updates only between frames so multi-byte reads stay coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_snap_r     <= 16'h0000;
      y_snap_r     <= 16'h0000;
      z_snap_r     <= 16'h0000;
      x_pend_r     <= 16'h0000;
      y_pend_r     <= 16'h0000;
      z_pend_r     <= 16'h0000;
      pend_valid_r <= 1'b0;
      data_ready_r <= 1'b0;
    end else if (sample_valid && !frame_active_s) begin
      x_snap_r     <= x_data;
      y_snap_r     <= y_data;
      z_snap_r     <= z_data;
      pend_valid_r <= 1'b0;
      data_ready_r <= 1'b1;
    end else if (pend_valid_r && !frame_active_s) begin
      x_snap_r     <= x_pend_r;
      y_snap_r     <= y_pend_r;
      z_snap_r     <= z_pend_r;
      pend_valid_r <= 1'b0;
      data_ready_r <= 1'b1;
    end else begin
      if (sample_valid) begin
        x_pend_r     <= x_data;
        y_pend_r     <= y_data;
        z_pend_r     <= z_data;
        pend_valid_r <= 1'b1;
      end
      // A deferred sample lands the cycle after CS rises, so its set wins over this clear.
      if (cs_rise_s && (data_rd_seen_r || data_hit_s)) begin
        data_ready_r <= 1'b0;
      end
    end
  end

  assign MISO        = miso_r;
  assign data_format = regs_r[DATA_FORMAT_A];
  assign power_ctl   = regs_r[POWER_CTL_A];
  assign measure     = regs_r[POWER_CTL_A][3];
  assign wr_strobe   = wr_strobe_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Self-checking bench for adxl345_spi_responder: an SPI mode-3 master
// drives frames and a register-map model predicts every returned byte.
module tb_adxl345_spi_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        CS;
  logic        spi_clk;
  logic        MOSI;
  logic        MISO;
  logic [15:0] x_data, y_data, z_data;
  logic        sample_valid;
  logic [7:0]  data_format, power_ctl;
  logic        measure;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] wbuf [16];
  logic [7:0] rbuf [16];
  logic [7:0] ebuf [16];

  // Reference model state
  logic [7:0]  m_regs [64];
  logic [15:0] m_x = 16'h0, m_y = 16'h0, m_z = 16'h0;
  logic        m_dr = 1'b0;
  int          m_strobes = 0;
  logic [5:0]  m_waddr = 6'd0;
  logic [7:0]  m_wdata = 8'h00;

  int          act_strobes = 0;
  logic [5:0]  act_waddr = 6'd0;
  logic [7:0]  act_wdata = 8'h00;

  adxl345_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .CS(CS), .spi_clk(spi_clk), .MOSI(MOSI), .MISO(MISO),
    .x_data(x_data), .y_data(y_data), .z_data(z_data), .sample_valid(sample_valid),
    .data_format(data_format), .power_ctl(power_ctl), .measure(measure),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Count strobe cycles and remember the last reported write.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      act_strobes <= act_strobes + 1;
      act_waddr   <= wr_addr;
      act_wdata   <= wr_data;
    end
  end

  function automatic bit m_writable(input int a);
    return (a >= 29 && a <= 42) || (a >= 44 && a <= 47) || a == 49 || a == 56;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (m_writable(a)) return m_regs[a];
    case (a)
      0:  return 8'hE5;
      48: return m_dr ? 8'h82 : 8'h02;
      50: return m_x[7:0];
      51: return m_x[15:8];
      52: return m_y[7:0];
      53: return m_y[15:8];
      54: return m_z[7:0];
      55: return m_z[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_regs[44] = 8'h0A;
    m_x = 16'h0; m_y = 16'h0; m_z = 16'h0;
    m_dr = 1'b0;
  endtask

  // Predict one complete frame: expected read bytes into ebuf, writes into the map.
  task automatic model_frame(input logic [7:0] cmd, input int nbytes);
    int a;
    bit hit;
    a = int'(cmd[5:0]);
    hit = 1'b0;
    for (int b = 0; b < nbytes; b++) begin
      if (cmd[7]) begin
        ebuf[b] = m_read(a);
        if (a >= 50 && a <= 55) hit = 1'b1;
      end else if (m_writable(a)) begin
        m_regs[a] = wbuf[b];
        m_strobes++;
        m_waddr = 6'(a);
        m_wdata = wbuf[b];
      end
      if (cmd[6]) a = (a + 1) % 64;
    end
    if (hit) m_dr = 1'b0;
  endtask

  task automatic model_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    m_x = x; m_y = y; m_z = z;
    m_dr = 1'b1;
  endtask

  task automatic drive_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    x_data = x; y_data = y; z_data = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // SPI master, mode 3: MOSI changes on the falling edge, MISO sampled before the rise.
  task automatic spi_frame(input logic [7:0] cmd, input int nbytes, input int tail_bits);
    logic [7:0] cur;
    logic [7:0] sh;
    int total;
    sh = 8'h00;
    total = (1 + nbytes) * 8 + tail_bits;
    @(negedge clk);
    CS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < total; k++) begin
      cur = (k < 8) ? cmd : wbuf[k / 8 - 1];
      spi_clk = 1'b0;
      MOSI = cur[7 - (k % 8)];
      repeat (HALF) @(negedge clk);
      sh = {sh[6:0], MISO};
      if ((k % 8) == 7 && k >= 8) rbuf[k / 8 - 1] = sh;
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    repeat (HALF) @(negedge clk);
    CS = 1'b1;
    MOSI = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    CS = 1'b1; spi_clk = 1'b1; MOSI = 1'b0; sample_valid = 1'b0;
    x_data = 16'h0; y_data = 16'h0; z_data = 16'h0;
    rst = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (MISO !== 1'b0) begin n_bad++; $display("FAIL reset_miso got %b want 0", MISO); end
    n_cmp++; if (data_format !== 8'h00) begin n_bad++; $display("FAIL reset_data_format got %h want 00", data_format); end
    n_cmp++; if (power_ctl !== 8'h00) begin n_bad++; $display("FAIL reset_power_ctl got %h want 00", power_ctl); end
    n_cmp++; if (measure !== 1'b0) begin n_bad++; $display("FAIL reset_measure got %b want 0", measure); end
    n_cmp++; if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); end
    n_cmp++; if (wr_addr !== 6'h00 || wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_wr_bus got %h/%h want 00/00", wr_addr, wr_data); end
    // Reset values of readable registers
    model_frame(8'h80, 1); spi_frame(8'h80, 1, 0);
    n_cmp++; if (rbuf[0] !== ebuf[0]) begin n_bad++; $display("FAIL reset_devid got %h want %h", rbuf[0], ebuf[0]); end
    model_frame(8'hAC, 1); spi_frame(8'hAC, 1, 0);
    n_cmp++; if (rbuf[0] !== ebuf[0]) begin n_bad++; $display("FAIL reset_bw_rate got %h want %h", rbuf[0], ebuf[0]); end
    model_frame(8'hB0, 1); spi_frame(8'hB0, 1, 0);
    n_cmp++; if (rbuf[0] !== ebuf[0]) begin n_bad++; $display("FAIL reset_int_source got %h want %h", rbuf[0], ebuf[0]); end
    n_cmp++; if (act_strobes !== 0) begin n_bad++; $display("FAIL devid_no_strobe got %0d want 0", act_strobes); end
  endtask

  task automatic test_format_write();
    wbuf[0] = 8'h04;
    model_frame(8'h31, 1); spi_frame(8'h31, 1, 0);
    n_cmp++; if (data_format !== m_regs[49]) begin n_bad++; $display("FAIL fmt_value got %h want %h", data_format, m_regs[49]); end
    n_cmp++; if (act_strobes !== m_strobes) begin n_bad++; $display("FAIL fmt_strobes got %0d want %0d", act_strobes, m_strobes); end
    n_cmp++; if (act_waddr !== m_waddr || act_wdata !== m_wdata) begin n_bad++; $display("FAIL fmt_wr_bus got %h/%h want %h/%h", act_waddr, act_wdata, m_waddr, m_wdata); end
    wbuf[0] = 8'h08;
    model_frame(8'h2D, 1); spi_frame(8'h2D, 1, 0);
    n_cmp++; if (power_ctl !== m_regs[45]) begin n_bad++; $display("FAIL pwr_value got %h want %h", power_ctl, m_regs[45]); end
    n_cmp++; if (measure !== 1'b1) begin n_bad++; $display("FAIL pwr_measure got %b want 1", measure); end
    n_cmp++; if (act_strobes !== m_strobes) begin n_bad++; $display("FAIL pwr_strobes got %0d want %0d", act_strobes, m_strobes); end
  endtask

  task automatic test_axis_burst();
    drive_sample(16'h0123, 16'hFEDC, 16'h0040);
    model_sample(16'h0123, 16'hFEDC, 16'h0040);
    repeat (2) @(negedge clk);
    model_frame(8'hB0, 1); spi_frame(8'hB0, 1, 0);
    n_cmp++; if (rbuf[0] !== ebuf[0]) begin n_bad++; $display("FAIL burst_dr_set got %h want %h", rbuf[0], ebuf[0]); end
    model_frame(8'hF2, 6); spi_frame(8'hF2, 6, 0);
    for (int b = 0; b < 6; b++) begin
      n_cmp++; if (rbuf[b] !== ebuf[b]) begin n_bad++; $display("FAIL burst_byte%0d got %h want %h", b, rbuf[b], ebuf[b]); end
    end
    model_frame(8'hB0, 1); spi_frame(8'hB0, 1, 0);
    n_cmp++; if (rbuf[0] !== ebuf[0]) begin n_bad++; $display("FAIL burst_dr_clear got %h want %h", rbuf[0], ebuf[0]); end
  endtask

  task automatic test_coherency();
    model_frame(8'hF2, 6);
    fork
      spi_frame(8'hF2, 6, 0);
      begin
        repeat (60) @(negedge clk);
        drive_sample(16'h1111, 16'h2222, 16'h3333);
      end
    join
    model_sample(16'h1111, 16'h2222, 16'h3333);
    for (int b = 0; b < 6; b++) begin
      n_cmp++; if (rbuf[b] !== ebuf[b]) begin n_bad++; $display("FAIL coh_old_byte%0d got %h want %h", b, rbuf[b], ebuf[b]); end
    end
    model_frame(8'hF2, 2); spi_frame(8'hF2, 2, 0);
    for (int b = 0; b < 2; b++) begin
      n_cmp++; if (rbuf[b] !== ebuf[b]) begin n_bad++; $display("FAIL coh_new_byte%0d got %h want %h", b, rbuf[b], ebuf[b]); end
    end
  endtask

  task automatic test_abort();
    wbuf[0] = 8'hA5;
    spi_frame(8'h31, 0, 5);
    n_cmp++; if (data_format !== m_regs[49]) begin n_bad++; $display("FAIL abort_value got %h want %h", data_format, m_regs[49]); end
    n_cmp++; if (act_strobes !== m_strobes) begin n_bad++; $display("FAIL abort_strobes got %0d want %0d", act_strobes, m_strobes); end
    model_frame(8'hB1, 1); spi_frame(8'hB1, 1, 0);
    n_cmp++; if (rbuf[0] !== ebuf[0]) begin n_bad++; $display("FAIL abort_next got %h want %h", rbuf[0], ebuf[0]); end
  endtask

  task automatic test_wrap();
    model_frame(8'hFF, 2); spi_frame(8'hFF, 2, 0);
    for (int b = 0; b < 2; b++) begin
      n_cmp++; if (rbuf[b] !== ebuf[b]) begin n_bad++; $display("FAIL wrap_byte%0d got %h want %h", b, rbuf[b], ebuf[b]); end
    end
    model_frame(8'hB1, 2); spi_frame(8'hB1, 2, 0);
    for (int b = 0; b < 2; b++) begin
      n_cmp++; if (rbuf[b] !== ebuf[b]) begin n_bad++; $display("FAIL nonmb_byte%0d got %h want %h", b, rbuf[b], ebuf[b]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int op, n;
    logic [15:0] rx, ry, rz;
    for (int it = 0; it < 30; it++) begin
      op = int'($urandom_range(0, 3));
      if (op == 3) begin
        rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
        drive_sample(rx, ry, rz);
        model_sample(rx, ry, rz);
        repeat (2) @(negedge clk);
      end else begin
        n = int'($urandom_range(1, 4));
        cmd = {(op == 0), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63))};
        for (int b = 0; b < n; b++) wbuf[b] = 8'($urandom);
        model_frame(cmd, n);
        spi_frame(cmd, n, 0);
        if (cmd[7]) begin
          for (int b = 0; b < n; b++) begin
            n_cmp++; if (rbuf[b] !== ebuf[b]) begin n_bad++; $display("FAIL rnd%0d_cmd%h_byte%0d got %h want %h", it, cmd, b, rbuf[b], ebuf[b]); end
          end
        end
      end
      n_cmp++; if (data_format !== m_regs[49] || power_ctl !== m_regs[45] || measure !== m_regs[45][3])
        begin n_bad++; $display("FAIL rnd%0d_cfg got %h/%h/%b want %h/%h/%b", it, data_format, power_ctl, measure, m_regs[49], m_regs[45], m_regs[45][3]); end
      n_cmp++; if (act_strobes !== m_strobes || act_waddr !== m_waddr || act_wdata !== m_wdata)
        begin n_bad++; $display("FAIL rnd%0d_strobe got %0d %h/%h want %0d %h/%h", it, act_strobes, act_waddr, act_wdata, m_strobes, m_waddr, m_wdata); end
    end
  endtask

  initial begin
    test_reset();
    test_format_write();
    test_axis_burst();
    test_coherency();
    test_abort();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adxl345_spi_responder.md
Name: adxl345_spi_responder

Overview:
- SPI mode-3 slave that emulates the ADXL345 register interface.
- It is the responder end of the transactions issued by the team's ADXL345 SPI master: command byte, then N write bytes or N read bytes.
- Used as an on-chip loopback target for bring-up and as the sensor model in master-side simulation.
- Holds a 64-entry register map, captures X/Y/Z samples from a stimulus source, and exports configuration registers to the fabric.

Parameters:
- DEVID, 8'hE5: value returned at address 0x00.
- SYNC_STAGES, 2: flip-flop stages on CS, spi_clk and MOSI (minimum 2).

Ports:
- clk  in  1  system clock; must be >= 8x the spi_clk frequency.
- rst  in  1  synchronous active-high reset.
- CS  in  1  chip select, active low.
- spi_clk  in  1  SPI clock, idle high (CPOL=1, CPHA=1).
- MOSI  in  1  serial data from master, MSB first.
- MISO  out  1  serial data to master, MSB first.
- x_data  in  16  X sample, two's complement.
- y_data  in  16  Y sample, two's complement.
- z_data  in  16  Z sample, two's complement.
- sample_valid  in  1  one-cycle pulse: x/y/z_data hold a new sample.
- data_format  out  8  register 0x31.
- power_ctl  out  8  register 0x2D.
- measure  out  1  power_ctl[3].
- wr_strobe  out  1  one-cycle pulse when a register is written over SPI.
- wr_addr  out  6  address of the last SPI write.
- wr_data  out  8  data of the last SPI write.

Behaviour:
- Reset: all outputs 0; state IDLE.
  - Register reset values: 0x00=DEVID, 0x2C=0x0A, 0x30=0x02; all others 0x00.
- Input handling: CS, spi_clk and MOSI pass through SYNC_STAGES flip-flops.
  - sclk_rise and sclk_fall are one-cycle pulses taken from the synchronized spi_clk.
  - Edges are ignored while the synchronized CS is high.
- State machine IDLE -> CMD -> DATA -> IDLE:
  - IDLE -> CMD when synchronized CS falls; bit counter = 0; MISO = 0.
  - On each sclk_rise, MOSI shifts into rx_shift and the 3-bit bit counter increments (wraps at 8).
  - CMD: on the 8th sclk_rise, latch rw=bit7, mb=bit6, addr=bit5:0, then go to DATA.
    - If rw=1, tx_shift is loaded with reg[addr] in the same cycle.
  - DATA: on each sclk_fall, MISO <= tx_shift[7] and tx_shift shifts left.
    - If rw=0, MISO stays 0.
  - DATA, at each byte end (8th sclk_rise):
    - Write (rw=0): if addr is writable, reg[addr] <= rx byte and wr_strobe pulses the next cycle with wr_addr/wr_data. Writes to non-writable addresses are dropped with no strobe.
    - Address update: if mb=1, addr <= addr+1, wrapping 0x3F -> 0x00. If mb=0, addr is unchanged.
    - Read (rw=1): reload tx_shift from the updated addr.
  - Any state -> IDLE on synchronized CS rising. A partial byte is discarded: no write and no strobe. MISO = 0.
- Register map:
  - Writable: 0x1D-0x2A, 0x2C-0x2F, 0x31, 0x38.
  - Read-only: 0x00, 0x30, 0x32-0x37, 0x39 (reads 0x00).
  - Reserved addresses read 0x00.
- Data registers, little-endian:
  - 0x32=X[7:0], 0x33=X[15:8], 0x34=Y[7:0], 0x35=Y[15:8], 0x36=Z[7:0], 0x37=Z[15:8].
  - sample_valid while CS is high (IDLE): the snapshot updates next cycle and INT_SOURCE[7] (DATA_READY) is set.
  - sample_valid while CS is low: the sample is held in a pending buffer and applied on the cycle after CS rises. A later pending sample overwrites an earlier one. The snapshot is therefore frozen during a frame, so multi-byte reads are coherent.
  - DATA_READY clears at CS rise for any frame that read any byte in 0x32-0x37.
  - Simultaneous clear and set at CS rise: set wins.
- Latency: a register written over SPI is visible on data_format/power_ctl and in wr_strobe one clk cycle after the 8th sclk_rise.
- Simultaneous events: rst dominates everything; CS rise in the same cycle as the 8th sclk_rise completes the byte first.

Decomposition:
- Package adxl345_pkg holds:
  - register address constants (DEVID_A, BW_RATE_A, POWER_CTL_A, INT_SOURCE_A, DATA_FORMAT_A, DATAX0_A ... DATAZ1_A, FIFO_STATUS_A);
  - reset values;
  - the writable-address function;
  - the state enum {IDLE, CMD, DATA}.
- Sub-module spi_edge_sync: synchronizers plus edge detect for CS and spi_clk, and synchronized MOSI.

Test Plan:
- Read DEVID: command 0x80 then 8 dummy clocks -> MISO bytes read 0xE5; wr_strobe never asserts.
- Format write: command 0x31, data 0x04 -> data_format=0x04; one wr_strobe with wr_addr=0x31, wr_data=0x04. Measure write: command 0x2D, data 0x08 -> power_ctl=0x08, measure=1.
- Axis burst read: x=0x0123, y=0xFEDC, z=0x0040, then command 0xF2 with 6 bytes -> 0x23 0x01 0xDC 0xFE 0x40 0x00; INT_SOURCE[7] clears after CS rise.
- Coherency: sample_valid (x=0x1111) mid-burst -> the burst returns the old sample; a following read returns 0x11 0x11.
- Abort: CS raised after 5 data bits of a write to 0x31 -> data_format unchanged, no wr_strobe; the next frame decodes correctly.
- Wrap and non-MB: command 0xFF (MB read at 0x3F) with 2 bytes -> 0x00 then 0xE5. Command 0xB1 (non-MB read of 0x31) with 2 bytes -> same byte twice.
